// File: rtl/inst_sram_axi_rd_bridge.sv
// inst_sram_axi_rd_bridge
// Instruction-fetch bridge: converts sram-like fetch requests into single-beat
// AXI4 reads and returns the read data in request order.
//
// Optional build macro: INST_BRIDGE_BUS_ERR_EN
//   Adds a sticky bus_err flag and the address of the first faulting fetch.
//   The addresses come from an in-order address FIFO.

module inst_sram_axi_rd_bridge #(
  parameter int        MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL       = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  // sram-like fetch port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_cached,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI4 read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI4 read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef INST_BRIDGE_BUS_ERR_EN
  ,
  output logic        bus_err,
  output logic [31:0] bus_err_addr
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  // Outstanding-request counter and AR holding register
  logic [CW-1:0] count_q,   count_d;
  logic          arvalid_q, arvalid_d;
  logic [31:0]   araddr_q,  araddr_d;
  logic [2:0]    arsize_q,  arsize_d;
  logic [3:0]    arcache_q, arcache_d;

  logic ar_free_s;
  logic accept_s;
  logic data_ok_s;
  logic rready_s;

  // Inputs that a read-only fetch port never needs; rid is ignored because
  // arid is constant and responses therefore come back in order.
  logic unused_s;
  assign unused_s = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};

  // Handshake decode: the AR register can take a new request when it is empty
  // or is draining this cycle; a full bridge may still accept when a response
  // retires in the same cycle.
  always_comb begin
    rready_s  = (count_q != {CW{1'b0}});
    data_ok_s = rvalid & rready_s & rlast;
    ar_free_s = ~arvalid_q | arready;
    accept_s  = inst_sram_req & ~inst_sram_wr & ar_free_s &
                ((count_q < MAX_CNT) | data_ok_s);
  end

  // Outstanding count: +1 on accept, -1 on retire, unchanged when both happen
  always_comb begin
    count_d = count_q;
    case ({accept_s, data_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // AR register next state: load on accept, drop valid on handshake, else hold
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arcache_d = arcache_q;
    if (accept_s) begin
      arvalid_d = 1'b1;
      araddr_d  = inst_sram_addr;
      arsize_d  = {1'b0, inst_sram_size};
      arcache_d = inst_sram_cached ? 4'b1111 : 4'b0000;
    end else if (arready) begin
      arvalid_d = 1'b0;
    end else begin
      arvalid_d = arvalid_q;
    end
  end

  // State registers for the counter and the AR channel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= {CW{1'b0}};
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arsize_q  <= 3'd0;
      arcache_q <= 4'd0;
    end else begin
      count_q   <= count_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arcache_q <= arcache_d;
    end
  end

  assign inst_sram_addr_ok = accept_s;
  assign inst_sram_data_ok = data_ok_s;
  assign inst_sram_rdata   = rdata;

  assign arid    = ARID_VAL;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = arcache_q;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_s;

`ifdef INST_BRIDGE_BUS_ERR_EN
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(MAX_OUTSTANDING - 1);

  // Circular pointer advance over a depth that need not be a power of two
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == LAST_PTR) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  // FIFO occupancy equals count_q, so no separate fill level is kept; a push
  // into a full FIFO only happens together with a pop of the same slot.
  logic [31:0]   fifo_q [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   bus_err_addr_q, bus_err_addr_d;
  logic          resp_err_s;

  // Pointer advance and first-error capture
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    bus_err_d      = bus_err_q;
    bus_err_addr_d = bus_err_addr_q;
    resp_err_s     = data_ok_s & (rresp != 2'b00);
    if (accept_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (data_ok_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (resp_err_s) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) begin
        bus_err_addr_d = fifo_q[rd_ptr_q];
      end else begin
        bus_err_addr_d = bus_err_addr_q;
      end
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // Address FIFO storage, pointers and sticky error state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= 32'd0;
      end
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= 32'd0;
    end else begin
      if (accept_s) begin
        fifo_q[wr_ptr_q] <= inst_sram_addr;
      end
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      bus_err_q      <= bus_err_d;
      bus_err_addr_q <= bus_err_addr_d;
    end
  end

  assign bus_err      = bus_err_q;
  assign bus_err_addr = bus_err_addr_q;
`endif

  inst_sram_axi_rd_bridge_chk #(.CW(CW)) u_chk (
    .clk     (clk),
    .resetn  (resetn),
    .rvalid  (rvalid),
    .count   (count_q)
  );

endmodule

// Protocol checker: a read response with nothing outstanding is a slave error
module inst_sram_axi_rd_bridge_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          resetn,
  input logic          rvalid,
  input logic [CW-1:0] count
);

  a_no_orphan_rvalid : assert property (
    @(posedge clk) disable iff (!resetn) !(rvalid && (count == {CW{1'b0}}))
  );

endmodule
